ahblite_sample_writer: RTL and testbench
========================================

Name: ahblite_sample_writer

Overview:
- AHB-lite initiator (master) that streams ADC-style samples into system memory, e.g. the RAMDATA region.
- Samples arrive on a valid/ready stream and are buffered in a small FIFO.
- Each sample is written as a zero-extended 32-bit single NONSEQ word transfer to incrementing addresses.
- Sits on a second master port of the AHB-lite fabric, alongside the Cortex-M0 core.

Parameters:
- DATA_WIDTH, 8, sample width; must be 1..32; zero-extended to 32 bits on HWDATA.
- FIFO_DEPTH, 4, sample buffer entries; must be a power of 2, ≥2.

Ports:
- HCLK  in  1  clock; all logic is rising-edge.
- HRESET  in  1  synchronous, active-high reset.
- start  in  1  1-cycle pulse that launches a job; ignored while busy.
- stop  in  1  abort request; honoured while busy.
- base_addr  in  32  job start address; bits [1:0] are forced to 0.
- len  in  16  number of words to write.
- smp_data  in  DATA_WIDTH  sample.
- smp_valid  in  1  sample valid.
- smp_ready  out  1  sample accepted when valid & ready.
- busy  out  1  job active.
- done  out  1  1-cycle pulse at job end.
- err  out  1  sticky bus-error flag; cleared by start.
- wr_count  out  16  words completed in the current/last job.
- HADDR  out  32  address.
- HTRANS  out  2  transfer type; only IDLE (2'b00) or NONSEQ (2'b10).
- HSIZE  out  3  constant 3'b010 (word).
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant 4'b0011.
- HMASTLOCK  out  1  constant 0.
- HWRITE  out  1  1 during NONSEQ, else 0.
- HWDATA  out  32  write data, valid in the data phase.
- HREADY  in  1  fabric ready.
- HRESP  in  1  fabric response; 1 = ERROR.

Behaviour:
- Reset values (HRESET=1 at an edge):
  - busy=0, done=0, err=0, wr_count=0, smp_ready=0.
  - HTRANS=IDLE, HWRITE=0, HADDR=0, HWDATA=0.
  - FIFO emptied; FSM to IDLE.
- Reset mid-transfer drops the transfer; HTRANS is IDLE on the cycle after reset.
- FSM states: IDLE, WAIT, ADDR, DATA.
- IDLE:
  - start & len≠0 → WAIT. Latch addr=base_addr&~3 and remaining=len; wr_count←0, err←0, FIFO flushed, busy←1.
  - start & len=0 → done pulses on the next cycle; no bus activity; err cleared; wr_count←0.
- WAIT:
  - HTRANS=IDLE.
  - FIFO non-empty → ADDR.
  - stop → IDLE with done pulse.
- ADDR:
  - Drive HTRANS=NONSEQ, HWRITE=1, HADDR=addr.
  - Held stable until an edge with HREADY=1, then → DATA.
  - FIFO head is popped on that edge.
- DATA:
  - HTRANS=IDLE; HWDATA={zeros, popped sample}, held until HREADY=1.
  - On HREADY=1 & HRESP=0: wr_count+1, addr+4 (mod 2^32), remaining−1.
    - remaining reaches 0 → IDLE with done.
    - else stop → IDLE with done.
    - else FIFO non-empty → ADDR; empty → WAIT.
  - On HRESP=1 (first error cycle, HREADY=0): err←1, → IDLE with done. wr_count excludes the failed word. The second error cycle sees HTRANS=IDLE.
- Transfers are non-pipelined: the minimum is 2 cycles per word with zero wait states.
- stop in ADDR is deferred until the current data phase completes. The address phase is never withdrawn once driven.
- FIFO:
  - smp_ready = busy & ~full.
  - A push and a pop in the same cycle are both legal; occupancy is unchanged.
  - When full, smp_ready=0 and the stalled producer holds its data.
  - Entries left at job end are discarded at the next start.
- done is a 1-cycle pulse. busy falls in the same cycle done rises.
- start while busy is ignored. A start coincident with done is ignored.

Optional Feature:
- Macro: SAMPLE_WRITER_CIRC_EN.
- Defined: when remaining reaches 0, addr reloads base_addr&~3 and remaining reloads len, and the job continues. wr_count still increments (wraps at 2^16). The job ends only on stop or bus error.
- Undefined: the job ends after len words as described in Behaviour.

Test Plan:
- base=0x2000_0000, len=4, samples 0x11,0x22,0x33,0x44, HREADY=1 → NONSEQ at 0x2000_0000/04/08/0C; HWDATA 0x11..0x44; done 1 cycle; wr_count=4; err=0.
- Same job with HREADY low 3 cycles in the 2nd address phase and the 3rd data phase → HADDR/HWDATA held stable during the stalls; identical final memory image.
- smp_valid held high with the bus stalled 20 cycles → smp_ready drops after FIFO_DEPTH(4) pushes; no sample lost or duplicated.
- ERROR response on the 2nd word (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1) → err=1, wr_count=1, done pulse, no further NONSEQ.
- stop asserted during the 3rd address phase of len=8 → 3rd word completes; done; wr_count=3. Then len=0 start → done next cycle, no NONSEQ.
- With SAMPLE_WRITER_CIRC_EN: base=0x2000_0100, len=2, 5 samples → addresses 0x100, 0x104, 0x100, 0x104, 0x100; no done until stop.

Source files
------------

// File: rtl/ahblite_sample_writer.sv
// ahblite_sample_writer: AHB-lite master that buffers a valid/ready sample
// stream in a small FIFO and writes each sample, zero-extended to 32 bits, as
// a single NONSEQ word transfer to incrementing addresses.
// Optional build macro SAMPLE_WRITER_CIRC_EN: circular mode, the job wraps back
// to base_addr after len words and only ends on stop or a bus error.
//
// state  | meaning
// S_IDLE | no job; waits for start
// S_WAIT | job active, FIFO empty; bus idle
// S_ADDR | NONSEQ address phase driven, held until HREADY
// S_DATA | data phase of the popped sample, held until HREADY
module ahblite_sample_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  start,
    input  logic                  stop,
    input  logic [31:0]           base_addr,
    input  logic [15:0]           len,
    input  logic [DATA_WIDTH-1:0] smp_data,
    input  logic                  smp_valid,
    output logic                  smp_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           wr_count,
    output logic [31:0]           HADDR,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic                  HWRITE,
    output logic [31:0]           HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA} state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  fifo_full, fifo_empty, push, pop;

    logic [31:0] addr_q, hwdata_q;
    logic [15:0] remaining_q, wr_count_q;
    logic        err_q, done_q, stop_pend_q;
`ifdef SAMPLE_WRITER_CIRC_EN
    logic [31:0] base_q;
    logic [15:0] len_q;
`endif

    logic job_start, zero_job, word_ok, bus_err, job_end, stop_req, last_word;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign busy       = (state_q != S_IDLE);
    assign smp_ready  = busy & ~fifo_full;
    assign push       = smp_valid & smp_ready;
    // a stop seen during an address phase is remembered until the word retires
    assign stop_req   = stop | stop_pend_q;
    assign last_word  = (remaining_q == 16'd1);

    assign done      = done_q;
    assign err       = err_q;
    assign wr_count  = wr_count_q;
    assign HADDR     = addr_q;
    assign HTRANS    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    assign HWRITE    = (state_q == S_ADDR);
    assign HWDATA    = hwdata_q;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_d   = state_q;
        job_start = 1'b0;
        zero_job  = 1'b0;
        pop       = 1'b0;
        word_ok   = 1'b0;
        bus_err   = 1'b0;
        job_end   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // start landing on the done cycle is ignored
                if (start && !done_q) begin
                    if (len != 16'd0) begin
                        job_start = 1'b1;
                        state_d   = S_WAIT;
                    end else begin
                        zero_job = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (stop_req) begin
                    job_end = 1'b1;
                    state_d = S_IDLE;
                end else if (!fifo_empty) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    pop     = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (HRESP) begin
                    bus_err = 1'b1;
                    job_end = 1'b1;
                    state_d = S_IDLE;
                end else if (HREADY) begin
                    word_ok = 1'b1;
`ifdef SAMPLE_WRITER_CIRC_EN
                    if (stop_req) begin
`else
                    if (last_word || stop_req) begin
`endif
                        job_end = 1'b1;
                        state_d = S_IDLE;
                    end else if (!fifo_empty) begin
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Job datapath: address, word counters, flags and write data
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q      <= '0;
            hwdata_q    <= '0;
            remaining_q <= '0;
            wr_count_q  <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
`ifdef SAMPLE_WRITER_CIRC_EN
            base_q      <= '0;
            len_q       <= '0;
`endif
        end else begin
            done_q <= job_end | zero_job;
            if (job_start) begin
                addr_q      <= base_addr & ~32'd3;
                remaining_q <= len;
                wr_count_q  <= '0;
                err_q       <= 1'b0;
`ifdef SAMPLE_WRITER_CIRC_EN
                base_q      <= base_addr & ~32'd3;
                len_q       <= len;
`endif
            end
            if (zero_job) begin
                wr_count_q <= '0;
                err_q      <= 1'b0;
            end
            if (pop) hwdata_q <= 32'(fifo_mem[rd_ptr_q]);
            if (word_ok) begin
                wr_count_q <= wr_count_q + 16'd1;
`ifdef SAMPLE_WRITER_CIRC_EN
                if (last_word) begin
                    addr_q      <= base_q;
                    remaining_q <= len_q;
                end else begin
                    addr_q      <= addr_q + 32'd4;
                    remaining_q <= remaining_q - 16'd1;
                end
`else
                addr_q      <= addr_q + 32'd4;
                remaining_q <= remaining_q - 16'd1;
`endif
            end
            if (bus_err) err_q <= 1'b1;
            if (job_start || job_end)  stop_pend_q <= 1'b0;
            else if (busy && stop)     stop_pend_q <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; a new job discards leftovers
    always_ff @(posedge HCLK) begin
        if (HRESET || job_start) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
        end
    end

    // FIFO storage
    always_ff @(posedge HCLK) begin
        if (push) fifo_mem[wr_ptr_q] <= smp_data;
    end

endmodule

// File: tb/tb_ahblite_sample_writer.sv
// Self-checking bench for ahblite_sample_writer: scoreboard of expected
// (address, data) writes filled as samples are accepted, drained by a bus monitor.
module tb_ahblite_sample_writer;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        start = 1'b0, stop = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] len = '0;
    logic [7:0]  smp_data = '0;
    logic        smp_valid = 1'b0;
    logic        smp_ready, busy, done, err;
    logic [15:0] wr_count;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK, HWRITE;
    logic        HREADY = 1'b1, HRESP = 1'b0;

    ahblite_sample_writer #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .stop(stop),
        .base_addr(base_addr), .len(len), .smp_data(smp_data), .smp_valid(smp_valid),
        .smp_ready(smp_ready), .busy(busy), .done(done), .err(err), .wr_count(wr_count),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad = 0;
    int nonseq_cnt = 0;
    int pushes = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  smp_tab[$];

    // bus monitor: checks stability during stalls and drains the scoreboard
    logic        mon_dphase = 1'b0, mon_astall = 1'b0, mon_dstall = 1'b0;
    logic [31:0] mon_addr, mon_prev_haddr, mon_prev_hwdata, mon_ea, mon_ed;
    always @(negedge HCLK) begin
        if (HRESET) begin
            mon_dphase = 1'b0;
            mon_astall = 1'b0;
            mon_dstall = 1'b0;
        end else begin
            if (mon_dphase) begin
                if (mon_dstall) begin
                    total++;
                    if (HWDATA !== mon_prev_hwdata) begin
                        bad++;
                        $display("FAIL hwdata_hold got=%h want=%h", HWDATA, mon_prev_hwdata);
                    end
                end
                if (HRESP) begin
                    mon_dphase = 1'b0;
                    mon_dstall = 1'b0;
                end else if (HREADY) begin
                    total++;
                    if (exp_addr_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_write got=%h:%h want=none", mon_addr, HWDATA);
                    end else begin
                        mon_ea = exp_addr_q.pop_front();
                        mon_ed = exp_data_q.pop_front();
                        if (mon_addr !== mon_ea || HWDATA !== mon_ed) begin
                            bad++;
                            $display("FAIL write got=%h:%h want=%h:%h", mon_addr, HWDATA, mon_ea, mon_ed);
                        end
                    end
                    mon_dphase = 1'b0;
                    mon_dstall = 1'b0;
                end else begin
                    mon_dstall      = 1'b1;
                    mon_prev_hwdata = HWDATA;
                end
            end
            if (HTRANS == 2'b10) begin
                total++;
                if (HWRITE !== 1'b1) begin
                    bad++;
                    $display("FAIL hwrite got=%b want=1", HWRITE);
                end
                if (mon_astall) begin
                    total++;
                    if (HADDR !== mon_prev_haddr) begin
                        bad++;
                        $display("FAIL haddr_hold got=%h want=%h", HADDR, mon_prev_haddr);
                    end
                end
                if (HREADY) begin
                    mon_dphase = 1'b1;
                    mon_addr   = HADDR;
                    nonseq_cnt++;
                    mon_astall = 1'b0;
                end else begin
                    mon_astall     = 1'b1;
                    mon_prev_haddr = HADDR;
                end
            end else if (mon_astall) begin
                total++;
                bad++;
                mon_astall = 1'b0;
                $display("FAIL addr_withdrawn got=%b want=10", HTRANS);
            end
        end
    end

    task automatic start_job(input logic [31:0] b, input logic [15:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        @(posedge HCLK); #1;
        start     = 1'b0;
    endtask

    // producer: offers smp_tab[0..n-1], holding each sample until accepted
    task automatic produce(input int n, input logic [31:0] b, input int jl);
        logic r;
        int g;
        for (int i = 0; i < n; i++) begin
            smp_valid = 1'b1;
            smp_data  = smp_tab[i];
            g = 0;
            r = 1'b0;
            while (!r && g < 300) begin
                @(negedge HCLK);
                r = smp_ready;
                @(posedge HCLK); #1;
                g++;
            end
            total++;
            if (!r) begin
                bad++;
                $display("FAIL push_timeout got=no_ready want=ready sample=%0d", i);
                break;
            end
            exp_addr_q.push_back(b + 32'(4 * (i % jl)));
            exp_data_q.push_back({24'h0, smp_tab[i]});
            pushes++;
        end
        smp_valid = 1'b0;
    endtask

    // bus slave: optional address/data stalls and an ERROR on word e_w
    task automatic run_bus(input int a_w, input int a_n, input int d_w, input int d_n,
                           input int e_w, input int budget, output int dc, output logic bd);
        int acc, cur_w, astall, dstall, errc, post;
        logic in_d, was_addr;
        acc = 0; cur_w = 0; astall = 0; dstall = 0; errc = 0; post = -1;
        in_d = 1'b0; dc = 0; bd = 1'bx;
        for (int c = 0; c < budget; c++) begin
            HREADY   = 1'b1;
            HRESP    = 1'b0;
            was_addr = (HTRANS == 2'b10) && !in_d;
            if (in_d) begin
                if (cur_w == e_w && errc == 0) begin
                    HRESP = 1'b1; HREADY = 1'b0; errc = 1;
                end else if (cur_w == e_w && errc == 1) begin
                    HRESP = 1'b1; errc = 2;
                end else if (cur_w == d_w && dstall < d_n) begin
                    HREADY = 1'b0; dstall++;
                end
            end else if (was_addr && acc + 1 == a_w && astall < a_n) begin
                HREADY = 1'b0; astall++;
            end
            if (done) begin
                dc++;
                if (dc == 1) bd = busy;
                if (post < 0) post = 4;
            end
            if (post == 0) break;
            @(posedge HCLK);
            if (in_d && HREADY) in_d = 1'b0;
            else if (was_addr && HREADY) begin
                in_d = 1'b1; acc++; cur_w = acc;
            end
            #1;
            if (post > 0) post--;
        end
        HREADY = 1'b1;
        HRESP  = 1'b0;
        total++;
        if (post < 0) begin
            bad++;
            $display("FAIL bus_timeout got=no_done want=done");
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (err !== 1'b0)        begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (wr_count !== 16'd0)  begin bad++; $display("FAIL reset_wr_count got=%h want=0", wr_count); end
        total++; if (smp_ready !== 1'b0)  begin bad++; $display("FAIL reset_smp_ready got=%b want=0", smp_ready); end
        total++; if (HTRANS !== 2'b00)    begin bad++; $display("FAIL reset_htrans got=%b want=00", HTRANS); end
        total++; if (HWRITE !== 1'b0)     begin bad++; $display("FAIL reset_hwrite got=%b want=0", HWRITE); end
        total++; if (HADDR !== 32'd0)     begin bad++; $display("FAIL reset_haddr got=%h want=0", HADDR); end
        total++; if (HWDATA !== 32'd0)    begin bad++; $display("FAIL reset_hwdata got=%h want=0", HWDATA); end
        total++; if (HSIZE !== 3'b010 || HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin
            bad++;
            $display("FAIL const_ctrl got=%b/%b/%b/%b want=010/000/0011/0", HSIZE, HBURST, HPROT, HMASTLOCK);
        end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
    endtask

    task automatic check_job(input string nm, input int dc, input logic bd, input int w_cnt,
                             input logic w_err, input int w_ns, input int ns0, input int w_left);
        total++; if (dc !== 1)            begin bad++; $display("FAIL %s_done_cycles got=%0d want=1", nm, dc); end
        total++; if (bd !== 1'b0)         begin bad++; $display("FAIL %s_busy_at_done got=%b want=0", nm, bd); end
        total++; if (wr_count !== 16'(w_cnt)) begin bad++; $display("FAIL %s_wr_count got=%0d want=%0d", nm, wr_count, w_cnt); end
        total++; if (err !== w_err)       begin bad++; $display("FAIL %s_err got=%b want=%b", nm, err, w_err); end
        total++; if (nonseq_cnt - ns0 != w_ns) begin bad++; $display("FAIL %s_nonseq got=%0d want=%0d", nm, nonseq_cnt - ns0, w_ns); end
        total++; if (exp_addr_q.size() != w_left) begin bad++; $display("FAIL %s_left got=%0d want=%0d", nm, exp_addr_q.size(), w_left); end
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic test_basic();
        int dc, ns0; logic bd;
        smp_tab = '{8'h11, 8'h22, 8'h33, 8'h44};
        ns0 = nonseq_cnt;
        start_job(32'h2000_0000, 16'd4);
        fork
            produce(4, 32'h2000_0000, 4);
            run_bus(0, 0, 0, 0, 0, 200, dc, bd);
        join
        check_job("basic", dc, bd, 4, 1'b0, 4, ns0, 0);
    endtask

    task automatic test_wait_states();
        int dc, ns0; logic bd;
        smp_tab = '{8'h11, 8'h22, 8'h33, 8'h44};
        ns0 = nonseq_cnt;
        start_job(32'h2000_0003, 16'd4);
        fork
            produce(4, 32'h2000_0000, 4);
            run_bus(2, 3, 3, 3, 0, 200, dc, bd);
        join
        check_job("wait", dc, bd, 4, 1'b0, 4, ns0, 0);
    endtask

    task automatic test_fifo_full();
        int dc, ns0, p0; logic bd;
        smp_tab = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        ns0 = nonseq_cnt;
        p0  = pushes;
        start_job(32'h2000_0040, 16'd8);
        fork
            produce(8, 32'h2000_0040, 8);
            run_bus(1, 20, 0, 0, 0, 400, dc, bd);
            begin
                repeat (10) @(negedge HCLK);
                total++; if (pushes - p0 != 4) begin bad++; $display("FAIL full_pushes got=%0d want=4", pushes - p0); end
                total++; if (smp_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", smp_ready); end
            end
        join
        check_job("full", dc, bd, 8, 1'b0, 8, ns0, 0);
    endtask

    task automatic test_bus_error();
        int dc, ns0; logic bd;
        smp_tab = '{8'h5A, 8'hA5};
        ns0 = nonseq_cnt;
        start_job(32'h2000_0200, 16'd4);
        fork
            produce(2, 32'h2000_0200, 4);
            run_bus(0, 0, 0, 0, 2, 200, dc, bd);
        join
        check_job("buserr", dc, bd, 1, 1'b1, 2, ns0, 1);
    endtask

    task automatic test_stop_and_zero_len();
        int dc, ns0; logic bd; logic hit;
        smp_tab = '{8'h01, 8'h02, 8'h03};
        ns0 = nonseq_cnt;
        hit = 1'b0;
        start_job(32'h2000_0300, 16'd8);
        fork
            produce(3, 32'h2000_0300, 8);
            run_bus(0, 0, 0, 0, 0, 200, dc, bd);
            for (int c = 0; c < 100; c++) begin
                @(posedge HCLK); #1;
                if (HTRANS == 2'b10 && nonseq_cnt - ns0 == 2) begin
                    stop = 1'b1;
                    @(posedge HCLK); #1;
                    stop = 1'b0;
                    hit  = 1'b1;
                    break;
                end
            end
        join
        total++; if (hit !== 1'b1) begin bad++; $display("FAIL stop_window got=%b want=1", hit); end
        check_job("stop", dc, bd, 3, 1'b0, 3, ns0, 0);
        ns0 = nonseq_cnt;
        start_job(32'h2000_0400, 16'd0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zlen_done got=%b want=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zlen_busy got=%b want=0", busy); end
        total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL zlen_wr_count got=%0d want=0", wr_count); end
        @(posedge HCLK); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zlen_done_width got=%b want=0", done); end
        repeat (4) @(posedge HCLK); #1;
        total++; if (nonseq_cnt != ns0) begin bad++; $display("FAIL zlen_nonseq got=%0d want=0", nonseq_cnt - ns0); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        start_job(32'h2000_0500, 16'd2);
        HREADY    = 1'b0;
        smp_valid = 1'b1;
        smp_data  = 8'h77;
        @(posedge HCLK); #1;
        smp_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (HTRANS == 2'b10) begin seen = 1'b1; break; end
            @(posedge HCLK); #1;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rmid_nonseq got=%b want=1", seen); end
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        HREADY = 1'b1;
        @(negedge HCLK);
        total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL rmid_htrans got=%b want=00", HTRANS); end
        total++; if (busy !== 1'b0 || smp_ready !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b%b want=00", busy, smp_ready); end
        @(posedge HCLK); #1;
    endtask

    task automatic test_circular();
        int ns0; logic saw_done; logic reached;
        smp_tab  = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        ns0      = nonseq_cnt;
        saw_done = 1'b0;
        reached  = 1'b0;
        start_job(32'h2000_0100, 16'd2);
        fork
            produce(5, 32'h2000_0100, 2);
            for (int c = 0; c < 200; c++) begin
                @(negedge HCLK);
                if (done) saw_done = 1'b1;
                if (wr_count == 16'd5) begin reached = 1'b1; break; end
            end
        join
        repeat (3) @(negedge HCLK);
        if (done) saw_done = 1'b1;
        total++; if (reached !== 1'b1) begin bad++; $display("FAIL circ_wr_count got=%0d want=5", wr_count); end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL circ_early_done got=%b want=0", saw_done); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL circ_busy got=%b want=1", busy); end
        @(posedge HCLK); #1;
        stop = 1'b1;
        @(posedge HCLK); #1;
        stop = 1'b0;
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL circ_stop got=%b%b want=10", done, busy); end
        total++; if (nonseq_cnt - ns0 != 5) begin bad++; $display("FAIL circ_nonseq got=%0d want=5", nonseq_cnt - ns0); end
        total++; if (exp_addr_q.size() != 0) begin bad++; $display("FAIL circ_left got=%0d want=0", exp_addr_q.size()); end
    endtask

    initial begin
        test_reset();
`ifdef SAMPLE_WRITER_CIRC_EN
        test_circular();
`else
        test_basic();
        test_wait_states();
        test_fifo_full();
        test_bus_error();
        test_stop_and_zero_len();
        test_reset_mid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

endmodule
